// File: rtl/btn_conditioner.sv
// Pushbutton conditioner: 2-flop synchronizer, per-channel debounce, and a
// press/held/repeating FSM that emits one-cycle press, repeat and release pulses.
module btn_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_RATE     = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             repeat_en,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX + 1);

  // Terminal values are one below the target: the edge that would reach the
  // target is the edge that acts, and the counter clears instead.
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, HELD, REPEATING} state_t;

  logic [N_BTN-1:0] sync1, sync2;
  logic [DW-1:0]    deb_cnt     [N_BTN];
  logic [DW-1:0]    deb_cnt_nxt [N_BTN];
  logic [TW-1:0]    timer       [N_BTN];
  logic [TW-1:0]    timer_nxt   [N_BTN];
  state_t           state       [N_BTN];
  state_t           state_nxt   [N_BTN];
  logic [N_BTN-1:0] level_nxt, rise, fall, rpt_fire;
  logic [N_BTN-1:0] press_d, release_d;

  // Synchronizer runs regardless of ena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      // NOTE: non-blocking assignments make sync2 take the old sync1, giving two real flop stages.
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // State register: debounce, level, FSM, repeat timer and registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these per-channel arrays are ordinary flops, not RAM, so they take the async reset too.
      for (int i = 0; i < N_BTN; i++) begin
        deb_cnt[i] <= '0;
        timer[i]   <= '0;
        state[i]   <= IDLE;
      end
      level         <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        deb_cnt[i] <= deb_cnt_nxt[i];
        timer[i]   <= timer_nxt[i];
        state[i]   <= state_nxt[i];
      end
      level         <= level_nxt;
      press_pulse   <= press_d;
      release_pulse <= release_d;
    end
  end

  // Next-state logic; with ena low every channel holds.
  always_comb begin
    // NOTE: every combinational output is defaulted first so no latch is inferred on any path.
    level_nxt = level;
    rise      = '0;
    fall      = '0;
    rpt_fire  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      deb_cnt_nxt[i] = deb_cnt[i];
      timer_nxt[i]   = timer[i];
      state_nxt[i]   = state[i];
      if (ena) begin
        if (sync2[i] == level[i]) begin
          deb_cnt_nxt[i] = '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_cnt_nxt[i] = '0;
          level_nxt[i]   = sync2[i];
          rise[i]        = sync2[i];
          fall[i]        = ~sync2[i];
        end else begin
          deb_cnt_nxt[i] = deb_cnt[i] + 1'b1;
        end

        // Release is handled first so it wins over a coincident repeat expiry.
        if (fall[i]) begin
          state_nxt[i] = IDLE;
          timer_nxt[i] = '0;
        end else if (rise[i]) begin
          state_nxt[i] = HELD;
          timer_nxt[i] = '0;
        end else begin
          case (state[i])
            HELD: begin
              if (!repeat_en) begin
                timer_nxt[i] = '0;
              end else if (timer[i] == DELAY_LAST) begin
                rpt_fire[i]  = 1'b1;
                state_nxt[i] = REPEATING;
                timer_nxt[i] = '0;
              end else begin
                timer_nxt[i] = timer[i] + 1'b1;
              end
            end
            REPEATING: begin
              if (!repeat_en) begin
                state_nxt[i] = HELD;
                timer_nxt[i] = '0;
              end else if (timer[i] == RATE_LAST) begin
                rpt_fire[i]  = 1'b1;
                timer_nxt[i] = '0;
              end else begin
                timer_nxt[i] = timer[i] + 1'b1;
              end
            end
            default: timer_nxt[i] = '0;
          endcase
        end
      end
    end
  end

  // Output decode feeding the pulse registers.
  always_comb begin
    press_d   = ena ? (rise | rpt_fire) : '0;
    release_d = ena ? fall : '0;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomized and directed bench for btn_conditioner: a behavioural model predicts
// every pulse into a scoreboard queue that a negedge monitor drains and compares.
module tb_btn_conditioner;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         ena = 1'b1;
  logic         repeat_en = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] level, press_pulse, release_pulse;

  btn_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .btn_raw(btn_raw), .repeat_en(repeat_en),
    .level(level), .press_pulse(press_pulse), .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int           edge_no;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] lvl;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   press_log [N][$];
  int   last_rel_edge [N];

  // Reference model: delayed view of the raw lines, a run length of disagreeing
  // samples per channel, and a count of repeat-enabled held cycles per channel.
  logic [N-1:0] m_d1, m_d2, m_lvl, m_pulse;
  int           m_stable [N];
  int           m_run    [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
  endtask

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_lvl = '0; m_pulse = '0;
    for (int i = 0; i < N; i++) begin
      m_stable[i] = 0;
      m_run[i]    = 0;
    end
    while (sb.size() != 0 && sb[sb.size()-1].edge_no >= edge_n) sb.delete(sb.size()-1);
  endtask

  // Predicts the effect of the next clock edge with the inputs now applied.
  task automatic model_edge();
    logic [N-1:0] seen, p, r;
    seen = m_d2;
    p = '0;
    r = '0;
    if (ena) begin
      for (int i = 0; i < N; i++) begin
        if (seen[i] !== m_lvl[i]) begin
          m_stable[i]++;
          if (m_stable[i] == D) begin
            m_stable[i] = 0;
            m_lvl[i]    = seen[i];
            m_run[i]    = 0;
            if (seen[i]) p[i] = 1'b1;
            else         r[i] = 1'b1;
          end
        end else begin
          m_stable[i] = 0;
        end
        if (m_lvl[i] && !p[i]) begin
          if (!repeat_en) m_run[i] = 0;
          else begin
            m_run[i]++;
            if (m_run[i] == RD || (m_run[i] > RD && (m_run[i] - RD) % RR == 0)) p[i] = 1'b1;
          end
        end
      end
    end
    m_d2 = m_d1;
    m_d1 = btn_raw;
    m_pulse = p | r;
    if ((p | r) != '0) sb.push_back('{edge_n + 1, p, r, m_lvl});
  endtask

  // One clock: apply inputs just after an edge, predict, advance to the next edge + 1.
  // ena is never dropped while a pulse is on display, so the pulse cycle is unambiguous.
  task automatic cyc(input logic [N-1:0] raw, input logic en, input logic rep);
    btn_raw   = raw;
    ena       = (!en && m_pulse != '0) ? 1'b1 : en;
    repeat_en = rep;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        while (sb.size() != 0 && sb[0].edge_no < edge_n) begin
          check("missed_pulse_edge", edge_n, sb[0].edge_no);
          void'(sb.pop_front());
        end
        if ((press_pulse | release_pulse) != '0) begin
          for (int i = 0; i < N; i++) begin
            if (press_pulse[i])   press_log[i].push_back(edge_n);
            if (release_pulse[i]) last_rel_edge[i] = edge_n;
          end
          if (sb.size() == 0) begin
            check("unexpected_pulse", {press_pulse, release_pulse}, 0);
          end else begin
            mon_e = sb.pop_front();
            check("pulse_edge", edge_n, mon_e.edge_no);
            check("press_pulse", press_pulse, mon_e.press);
            check("release_pulse", release_pulse, mon_e.rel);
            check("level_at_pulse", level, mon_e.lvl);
          end
        end
      end
    end
  end

  initial begin
    int k, base;
    int exp4 [6];
    logic [N-1:0] rnd_raw;
    logic rnd_rep;

    for (int i = 0; i < N; i++) last_rel_edge[i] = -1;
    model_reset();

    // Reset acts with no clock edge, even with all buttons pressed.
    btn_raw = '1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_level", level, 0);
    check("reset_press", press_pulse, 0);
    check("reset_release", release_pulse, 0);
    repeat (2) @(posedge clk);
    #1 btn_raw = '0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Clean press and release on channel 0.
    k = edge_n + 1;
    repeat (9) cyc(4'b0001, 1'b1, 1'b0);
    check("clean_press_latency", press_log[0].size() > 0 ? press_log[0][press_log[0].size()-1] : -1, k + 5);
    check("level_after_press", level, 4'b0001);
    k = edge_n + 1;
    repeat (9) cyc(4'b0000, 1'b1, 1'b0);
    check("clean_release_latency", last_rel_edge[0], k + 5);

    // Bounce on channel 2 every 2 cycles, then held.
    for (int c = 0; c < 20; c++) cyc(((c / 2) % 2 == 0) ? 4'b0100 : 4'b0000, 1'b1, 1'b0);
    check("bounce_quiet", press_log[2].size(), 0);
    k = edge_n + 1;
    repeat (9) cyc(4'b0100, 1'b1, 1'b0);
    check("bounce_press_count", press_log[2].size(), 1);
    if (press_log[2].size() == 1) check("bounce_press_edge", press_log[2][0], k + 5);
    repeat (9) cyc(4'b0000, 1'b1, 1'b0);

    // Auto-repeat on channel 1, repeat_en dropped at t0+14, release coinciding with a repeat.
    base = press_log[1].size();
    k = edge_n + 1;
    for (int j = 0; j < 53; j++) cyc((j < 40) ? 4'b0010 : 4'b0000, 1'b1, !(j >= 19 && j <= 26));
    exp4 = '{k + 5, k + 15, k + 18, k + 36, k + 39, k + 42};
    check("repeat_count", press_log[1].size(), base + 6);
    if (press_log[1].size() == base + 6)
      for (int j = 0; j < 6; j++) check("repeat_edge", press_log[1][base + j], exp4[j]);
    check("repeat_release_edge", last_rel_edge[1], k + 45);

    // ena freeze on channel 3 for 5 cycles, two cycles into the debounce.
    k = edge_n + 1;
    for (int j = 0; j < 16; j++) cyc(4'b1000, !(j >= 3 && j <= 7), 1'b0);
    check("ena_freeze_press_edge", press_log[3].size() > 0 ? press_log[3][press_log[3].size()-1] : -1, k + 10);
    repeat (9) cyc(4'b0000, 1'b1, 1'b0);

    // Simultaneous press on channels 0 and 1.
    k = edge_n + 1;
    repeat (9) cyc(4'b0011, 1'b1, 1'b0);
    check("simul_press_ch0", press_log[0][press_log[0].size()-1], k + 5);
    check("simul_press_ch1", press_log[1][press_log[1].size()-1], k + 5);
    repeat (9) cyc(4'b0000, 1'b1, 1'b0);

    // Reset while channel 1 is repeating with the button held.
    for (int j = 0; j < 17; j++) cyc(4'b0010, 1'b1, 1'b1);
    check("pre_reset_level", level, 4'b0010);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_level", level, 0);
    check("midrst_press", press_pulse, 0);
    check("midrst_release", release_pulse, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    base = press_log[1].size();
    k = edge_n + 1;
    repeat (17) cyc(4'b0010, 1'b1, 1'b1);
    check("post_reset_count", press_log[1].size(), base + 2);
    if (press_log[1].size() == base + 2) begin
      check("post_reset_press_edge", press_log[1][base], k + 5);
      check("post_reset_repeat_edge", press_log[1][base + 1], k + 15);
    end
    repeat (9) cyc(4'b0000, 1'b1, 1'b0);

    // Randomized traffic on all channels, ena and repeat_en.
    rnd_raw = '0;
    rnd_rep = 1'b1;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) rnd_raw[i] = ~rnd_raw[i];
      if ($urandom_range(0, 19) == 0) rnd_rep = ~rnd_rep;
      cyc(rnd_raw, $urandom_range(0, 9) != 0, rnd_rep);
      if (c % 100 == 99) check("random_level", level, m_lvl);
    end

    repeat (12) cyc(4'b0000, 1'b1, 1'b0);
    check("final_level_model", level, m_lvl);
    check("final_level_zero", level, 0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Input-conditioning stage directly upstream of the advanced counter core.
- Takes raw asynchronous pushbutton lines from the dedicated inputs.
- Synchronizes and debounces each line, then emits clean one-cycle press/release pulses plus optional auto-repeat.
- The counter consumes the pulses as up/down/load/clear commands.

Parameters:
- N_BTN, 4: number of independent button channels.
- DEBOUNCE_CYCLES, 1000: consecutive stable cycles required to accept a level change; must be >= 1.
- REPEAT_DELAY, 500000: cycles from the accepted press to the first auto-repeat pulse; must be >= 1.
- REPEAT_RATE, 100000: cycles between subsequent auto-repeat pulses; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  enable; low freezes debounce and repeat timers.
- btn_raw  input  N_BTN  raw, asynchronous button levels (1 = pressed).
- repeat_en  input  1  global auto-repeat enable.
- level  output  N_BTN  debounced button level.
- press_pulse  output  N_BTN  one-cycle pulse on accepted press and on each auto-repeat.
- release_pulse  output  N_BTN  one-cycle pulse on accepted release.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low.
- Reset values: all outputs, synchronizer flops, counters and FSM states clear to 0/IDLE immediately on rst_n low.
- Synchronizer: 2-flop per channel (sync1, sync2). Runs regardless of ena.
- Debounce counter (per channel, width $clog2(DEBOUNCE_CYCLES+1)):
  - Increments on each enabled edge where sync2 != level.
  - Clears on any edge where sync2 == level (bounce restarts the count).
  - On the edge where the counter would reach DEBOUNCE_CYCLES, level toggles and the counter clears.
- Latency: raw change set up before edge k -> level changes at edge k+1+DEBOUNCE_CYCLES (DEBOUNCE_CYCLES+2 edges including k).
- Pulses: registered; high for exactly the one cycle following the level-change edge.
  - press_pulse on 0->1.
  - release_pulse on 1->0.
  - press_pulse and release_pulse are never high together on the same channel.
- Per-channel FSM:
  - IDLE: level=0. Accepted press -> HELD, press_pulse, repeat timer cleared.
  - HELD: level=1, timer counts enabled cycles while repeat_en=1.
    - Timer reaches REPEAT_DELAY -> press_pulse, enter REPEATING, timer cleared.
    - repeat_en=0 holds the timer at 0.
  - REPEATING: timer reaches REPEAT_RATE -> press_pulse, timer cleared.
    - repeat_en=0 -> HELD with timer cleared; re-enabling restarts the full REPEAT_DELAY.
  - Any state: accepted release -> IDLE, release_pulse, timer cleared. Release wins over a coincident repeat expiry (no press_pulse that cycle).
- Timer width: $clog2(max(REPEAT_DELAY, REPEAT_RATE)+1). No wrap; comparison is exact equality, then clear.
- ena=0:
  - Debounce counters, timers and FSM states hold.
  - press_pulse and release_pulse are forced 0; level holds.
  - A pending level change completes only after ena returns high.
- Channels are fully independent; simultaneous presses produce simultaneous pulses.
- Reset mid-operation: level returns to 0 even if the button is held. After rst_n deasserts, a held button is re-debounced and yields a fresh press_pulse after DEBOUNCE_CYCLES+2 edges.

Test Plan:
Parameters for all scenarios: N_BTN=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, ena=1 unless stated.
1. Reset: rst_n=0 with btn_raw=4'hF -> level=0, press_pulse=0 and release_pulse=0 immediately, without a clock edge.
2. Clean press: btn_raw[0] 0->1 before edge k, held -> level[0]=1 and press_pulse[0]=1 after edge k+5, pulse exactly 1 cycle. Release gives release_pulse[0] after the same latency.
3. Bounce: btn_raw[2] toggles every 2 cycles for 20 cycles, then held high -> no pulses during bouncing; one press_pulse[2] 6 edges after the last transition.
4. Auto-repeat: repeat_en=1, hold btn_raw[1]; initial press_pulse at cycle t0 -> further pulses at t0+10, +13, +16, +19, ... Release -> one release_pulse[1], no pulse after it. Drop repeat_en at t0+14 -> no pulses until re-enabled, then the first pulse comes 10 cycles after re-enable.
5. ena freeze and independence:
   - Press btn_raw[3]; drop ena 2 cycles into debounce for 5 cycles -> level[3] change delayed by exactly 5 cycles.
   - Simultaneous press of btn_raw[0] and btn_raw[1] -> press_pulse=4'b0011 in the same cycle.
6. Reset mid-repeat: assert rst_n while channel 1 is in REPEATING with btn held -> all outputs 0 at once. After deassert, press_pulse[1] returns after 6 edges, and the next repeat comes 10 cycles later.
